// File: rtl/pipelined_controller.sv
// pipelined_controller: ID-stage decoder feeding a registered ID/EX control
// stage, with load-use stall, branch/jump flush and a syscall drain/halt FSM.
//
// Handshake: the IF/ID register offers an instruction whenever instrValid=1;
// it is consumed on a rising edge only when idStall=0 and flush=0. While
// idStall=1 the IF/ID register and PC must hold and present the same
// instruction again.
//
// Optional build macro PIPECTRL_STALL_CNT_EN adds a saturating 16-bit
// stallCount output counting stall cycles that were not flushed.
module pipelined_controller #(
    parameter int CTRL_W       = 32,
    parameter int DRAIN_CYCLES = 3,
    parameter int REG_ADDR_W   = 5
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [31:0]           instr,
    input  logic                  instrValid,
    input  logic                  flush,
    input  logic                  resume,
    output logic                  idStall,
    output logic [CTRL_W-1:0]     exCtrl,
    output logic [REG_ADDR_W-1:0] exDest,
    output logic                  exValid,
    output logic                  halted,
    output logic [1:0]            dbgState
`ifdef PIPECTRL_STALL_CNT_EN
    ,
    output logic [15:0]           stallCount
`endif
);

    // ALU operation codes
    localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRA = 4'd1, ALU_SRL = 4'd2, ALU_NOR = 4'd3;
    localparam logic [3:0] ALU_ADD = 4'd5, ALU_SUB = 4'd6, ALU_AND = 4'd7, ALU_OR = 4'd8;
    localparam logic [3:0] ALU_SLT = 4'd9, ALU_SLTU = 4'd10;
    // ALU X operand: rs, rt, PC ; ALU Y operand: rt, zext imm, sext imm, shamt, rs, const 4, zero
    localparam logic [1:0] X_RS = 2'd0, X_RT = 2'd1, X_PC = 2'd2;
    localparam logic [2:0] Y_RT = 3'd0, Y_ZEXT = 3'd1, Y_SEXT = 3'd2, Y_SHAMT = 3'd3;
    localparam logic [2:0] Y_RS = 3'd4, Y_FOUR = 3'd5, Y_ZERO = 3'd6;
    // Next-PC select: sequential, branch-if-equal, branch-if-not-equal, jump-register
    localparam logic [1:0] PC_SEQ = 2'd0, PC_BEQ = 2'd1, PC_BNE = 2'd2, PC_JR = 2'd3;
    // Destination select: rd, none (r0), rt, r31
    localparam logic [1:0] DST_RD = 2'd0, DST_NONE = 2'd1, DST_RT = 2'd2, DST_RA = 2'd3;

    typedef enum logic [1:0] { ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_HALT = 2'd2 } state_t;

    state_t state, stateNext;
    logic [3:0] cnt, cntNext;

    logic [5:0] opc, funct;
    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic [3:0] aop;
    logic [1:0] ax, dc, pcw;
    logic [2:0] ay;
    logic we, src, ram, jmp, sys, lb, bz, sup;
    logic [31:0] decWord;
    logic [CTRL_W-1:0] decWide;
    logic [REG_ADDR_W-1:0] decDest;
    logic exIsLoad, hazard, accept;
    logic unused_bits;

    assign opc   = instr[31:26];
    assign funct = instr[5:0];
    assign rs    = REG_ADDR_W'(instr[25:21]);
    assign rt    = REG_ADDR_W'(instr[20:16]);
    assign rd    = REG_ADDR_W'(instr[15:11]);
    assign unused_bits = ^instr[10:6];

    // Instruction decode into control-word fields; unsupported ops give sup=0
    always_comb begin
        aop = ALU_SLL; ax = X_RS; ay = Y_RT; we = 1'b0; dc = DST_NONE; src = 1'b0;
        ram = 1'b0; pcw = PC_SEQ; jmp = 1'b0; sys = 1'b0; lb = 1'b0; bz = 1'b0; sup = 1'b1;
        case (opc)
            6'h00: begin
                we = 1'b1; dc = DST_RD; src = 1'b1;
                case (funct)
                    6'h20, 6'h21: aop = ALU_ADD;
                    6'h22: aop = ALU_SUB;
                    6'h24: aop = ALU_AND;
                    6'h25: aop = ALU_OR;
                    6'h27: aop = ALU_NOR;
                    6'h2A: aop = ALU_SLT;
                    6'h2B: aop = ALU_SLTU;
                    6'h00: begin aop = ALU_SLL; ax = X_RT; ay = Y_SHAMT; end
                    6'h03: begin aop = ALU_SRA; ax = X_RT; ay = Y_SHAMT; end
                    6'h02: begin aop = ALU_SRL; ax = X_RT; ay = Y_SHAMT; end
                    6'h06: begin aop = ALU_SRL; ax = X_RT; ay = Y_RS; end
                    6'h08: begin we = 1'b0; dc = DST_NONE; src = 1'b0; pcw = PC_JR; end
                    6'h0C: begin we = 1'b0; dc = DST_NONE; src = 1'b0; sys = 1'b1; end
                    default: sup = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin aop = ALU_ADD;  ay = Y_SEXT; we = 1'b1; dc = DST_RT; src = 1'b1; end
            6'h0C:        begin aop = ALU_AND;  ay = Y_ZEXT; we = 1'b1; dc = DST_RT; src = 1'b1; end
            6'h0D:        begin aop = ALU_OR;   ay = Y_ZEXT; we = 1'b1; dc = DST_RT; src = 1'b1; end
            6'h0A:        begin aop = ALU_SLT;  ay = Y_SEXT; we = 1'b1; dc = DST_RT; src = 1'b1; end
            6'h0B:        begin aop = ALU_SLTU; ay = Y_SEXT; we = 1'b1; dc = DST_RT; src = 1'b1; end
            6'h23:        begin aop = ALU_ADD;  ay = Y_SEXT; we = 1'b1; dc = DST_RT; end
            6'h24:        begin aop = ALU_ADD;  ay = Y_SEXT; we = 1'b1; dc = DST_RT; lb = 1'b1; end
            6'h2B:        begin aop = ALU_ADD;  ay = Y_SEXT; ram = 1'b1; end
            6'h04:        begin aop = ALU_SUB;  pcw = PC_BEQ; end
            6'h05:        begin aop = ALU_SUB;  pcw = PC_BNE; end
            6'h01:        begin aop = ALU_SLT;  ay = Y_ZERO; bz = 1'b1; end
            6'h02:        begin jmp = 1'b1; end
            6'h03:        begin aop = ALU_ADD; ax = X_PC; ay = Y_FOUR; we = 1'b1; dc = DST_RA;
                                src = 1'b1; jmp = 1'b1; end
            default:      sup = 1'b0;
        endcase
    end

    // Pack fields into the control word and select the write destination
    always_comb begin
        decWord = sup ? {aop, ax, ay, we, dc, src, ram, pcw, jmp, sys, lb, bz, 12'h000} : 32'h0;
        decWide = '0;
        decWide[31:0] = decWord;
        case (dc)
            DST_RD:  decDest = rd;
            DST_RT:  decDest = rt;
            DST_RA:  decDest = REG_ADDR_W'(31);
            default: decDest = '0;
        endcase
    end

    assign exIsLoad = exValid & exCtrl[22] & ~exCtrl[19];
    assign hazard   = exIsLoad & (exDest != '0) & instrValid & ((exDest == rs) | (exDest == rt));
    assign accept   = ~flush & ~idStall & instrValid & sup & decWord[14];

    // FSM state and drain counter register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= ST_RUN;
            cnt   <= 4'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // FSM next state: accepted syscall starts the drain, drain ends in halt
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            ST_RUN: begin
                if (accept) begin
                    stateNext = ST_DRAIN;
                    cntNext   = 4'(DRAIN_CYCLES);
                end
            end
            ST_DRAIN: begin
                if (cnt <= 4'd1) begin
                    stateNext = ST_HALT;
                    cntNext   = 4'd0;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            ST_HALT: begin
                if (resume) stateNext = ST_RUN;
            end
            default: begin
                stateNext = ST_RUN;
                cntNext   = 4'd0;
            end
        endcase
    end

    // FSM outputs: stall on unflushed hazard or whenever not running
    always_comb begin
        idStall  = (hazard & ~flush) | (state != ST_RUN);
        halted   = (state == ST_HALT);
        dbgState = state;
    end

    // ID/EX stage register: flush, stall, invalid or unsupported all insert a bubble
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            exCtrl  <= '0;
            exDest  <= '0;
            exValid <= 1'b0;
        end else if (flush || idStall || !instrValid || !sup) begin
            exCtrl  <= '0;
            exDest  <= '0;
            exValid <= 1'b0;
        end else begin
            exCtrl  <= decWide;
            exDest  <= decDest;
            exValid <= 1'b1;
        end
    end

`ifdef PIPECTRL_STALL_CNT_EN
    // Saturating count of stall cycles not overridden by a flush
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) stallCount <= 16'h0000;
        else if (idStall && !flush && stallCount != 16'hFFFF) stallCount <= stallCount + 16'h0001;
    end
`endif

endmodule
